// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard / stall controller beside the ID stage: multi-cycle load bubbles,
// memory-wait freeze, taken-branch flush, and saturating stall/flush counters.
//
// state | meaning
// IDLE  | no bubble in progress; hz evaluated every cycle
// STALL | inserting the remaining bubbles of a load-use hazard
module hazard_stall_ctrl #(
   parameter int REG_ADDR_W = 3,
   parameter int LOAD_LAT   = 2,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic                  ex_mem_read,
   input  logic                  mem_busy,
   input  logic                  branch_taken,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  haz_mux_con,
   output logic                  pipe_hold,
   output logic                  ifid_flush,
   output logic                  idex_flush,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_events
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      STALL = 2'b01
   } state_t;

   localparam logic [3:0]       REM_INIT = 4'(LOAD_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t     state, state_nxt;
   logic [3:0] rem, rem_nxt;
   logic       hz;
   logic       stall_inc, flush_inc;

   assign hz = ex_mem_read & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         rem          <= 4'd0;
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         state <= state_nxt;
         rem   <= rem_nxt;
         if (stall_inc && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_ONE;
         if (flush_inc && (flush_events != '1))
            flush_events <= flush_events + CNT_ONE;
      end
   end

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      haz_mux_con = 1'b1;
      pipe_hold   = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      state_nxt   = state;
      rem_nxt     = rem;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;

      if (mem_busy) begin
         // full freeze; anything else this cycle is re-presented later
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         pipe_hold  = 1'b1;
      end else if (branch_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         flush_inc  = 1'b1;
         state_nxt  = IDLE;
         rem_nxt    = 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (hz) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  haz_mux_con = 1'b0;
                  stall_inc   = 1'b1;
                  if (LOAD_LAT > 1) begin
                     state_nxt = STALL;
                     rem_nxt   = REM_INIT;
                  end
               end
            end
            STALL: begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               haz_mux_con = 1'b0;
               stall_inc   = 1'b1;
               rem_nxt     = rem - 4'd1;
               if (rem <= 4'd1) begin
                  state_nxt = IDLE;
                  rem_nxt   = 4'd0;
               end
            end
            default: begin
               state_nxt = IDLE;
               rem_nxt   = 4'd0;
            end
         endcase
      end

      // reset overrides the Mealy outputs even though inputs may still show a hazard
      if (rst) begin
         pc_write    = 1'b1;
         ifid_write  = 1'b1;
         haz_mux_con = 1'b1;
         pipe_hold   = 1'b0;
         ifid_flush  = 1'b0;
         idex_flush  = 1'b0;
      end
   end

endmodule
